// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit holding register.
// One IDLE edge picks a winner; each following GRANT edge writes that winner's slice into q.
module dff_reg_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           lock,
  input  logic [NREQ*WIDTH-1:0]     wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy,
  output logic [WIDTH-1:0]          q
);
  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_n;
  logic [OW-1:0]     ptr, ptr_n, owner_n, win, hi, lo;
  logic              hi_vld;
  logic [CW-1:0]     cnt, cnt_n, cnt_inc;
  logic [NREQ-1:0]   gnt_n;
  logic              busy_n;
  logic [WIDTH-1:0]  q_n;
  logic [WIDTH-1:0]  slice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice[i] = wdata[i*WIDTH +: WIDTH];
  end

  // Descending scan leaves the lowest set index in each half: hi is at/after ptr, lo wraps below it.
  always_comb begin
    hi     = '0;
    lo     = '0;
    hi_vld = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        if (OW'(j) >= ptr) begin
          hi     = OW'(j);
          hi_vld = 1'b1;
        end else begin
          lo = OW'(j);
        end
      end
    end
    win = hi_vld ? hi : lo;
  end

  assign cnt_inc = cnt + CW'(1);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    cnt_n   = cnt;
    gnt_n   = gnt;
    busy_n  = busy;
    q_n     = q;
    unique case (state)
      IDLE: begin
        if (|req) begin
          owner_n = win;
          gnt_n   = NREQ'(1) << win;
          busy_n  = 1'b1;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        q_n   = slice[owner];
        cnt_n = cnt_inc;
        if (!(lock[owner] && req[owner] && (cnt_inc < CW'(MAX_HOLD)))) begin
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          ptr_n   = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      q     <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
      busy  <= busy_n;
      q     <= q_n;
    end
  end
endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Scoreboard bench: driver applies stimulus at negedge and queues the model's post-edge outputs;
// monitor pops and compares just after each rising edge.
module tb_dff_reg_arbiter;
  localparam int WIDTH    = 8;
  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 4;
  localparam int OW       = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ-1:0]       lock = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
  logic [NREQ-1:0]       gnt;
  logic [OW-1:0]         owner;
  logic                  busy;
  logic [WIDTH-1:0]      q;

  dff_reg_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .owner(owner), .busy(busy), .q(q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic [OW-1:0]    owner;
    logic             busy;
    logic [WIDTH-1:0] q;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // reference model: transaction-level view of the arbiter
  int               m_busy, m_owner, m_ptr, m_writes;
  logic [WIDTH-1:0] m_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_writes = 0; m_q = '0;
  endtask

  task automatic model_edge(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                            input logic [NREQ*WIDTH-1:0] w);
    if (m_busy == 0) begin
      if (r != 0) begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (r[c]) begin
            m_owner = c;
            break;
          end
        end
        m_busy = 1;
        m_writes = 0;
      end
    end else begin
      m_q = w[m_owner*WIDTH +: WIDTH];
      m_writes++;
      if (!(l[m_owner] && r[m_owner] && m_writes < MAX_HOLD)) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % NREQ;
      end
    end
  endtask

  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                      input logic [NREQ*WIDTH-1:0] w);
    exp_t e;
    logic [31:0] ow;
    @(negedge clk);
    req = r; lock = l; wdata = w;
    model_edge(r, l, w);
    ow = m_owner;
    e.gnt   = m_busy ? (NREQ'(1) << m_owner) : '0;
    e.owner = ow[OW-1:0];
    e.busy  = (m_busy != 0);
    e.q     = m_q;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("gnt", 32'(gnt), 32'(e.gnt));
        chk("owner", 32'(owner), 32'(e.owner));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("q", 32'(q), 32'(e.q));
      end
    end
  end

  initial begin : driver
    logic [NREQ*WIDTH-1:0] w;
    model_reset();
    // reset held with all requests active
    req = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wdata = {$urandom, $urandom};
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_q", 32'(q), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_owner", 32'(owner), 0);
    end
    req = '0;
    rst = 1'b1;

    // fair rotation: owners 0,1,2,3,0
    for (int i = 0; i < 10; i++) step(4'b1111, 4'b0000, {8'h40, 8'h30, 8'h20, 8'h10});
    // wrap: grant 3, then 1001 -> 0, then 1001 -> 3
    repeat (2) step(4'b1000, 4'b0000, {8'h43, 8'h33, 8'h23, 8'h13});
    repeat (2) step(4'b1001, 4'b0000, {8'h44, 8'h34, 8'h24, 8'h14});
    repeat (2) step(4'b1001, 4'b0000, {8'h45, 8'h35, 8'h25, 8'h15});
    // single request with ptr back at 0
    repeat (2) step(4'b0001, 4'b0000, {8'h00, 8'h00, 8'h00, 8'hA5});
    step(4'b0000, 4'b0000, '0);
    // move ptr to 0, then lock bound: 1,2,3,4 written, 5 never
    repeat (2) step(4'b1000, 4'b0000, {8'h99, 8'h00, 8'h00, 8'h00});
    step(4'b0011, 4'b0001, {8'h00, 8'h00, 8'hEE, 8'h01});
    for (int v = 1; v <= 5; v++) step(4'b0011, 4'b0001, {8'h00, 8'h00, 8'hEE, 8'(v)});
    step(4'b0000, 4'b0000, '0);
    // early release after 2 writes, then ptr=1 picks requester 1
    repeat (2) step(4'b1000, 4'b0000, {8'h98, 8'h00, 8'h00, 8'h00});
    step(4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h61});
    step(4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h62});
    step(4'b0001, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h63});
    repeat (2) step(4'b0011, 4'b0000, {8'h00, 8'h00, 8'h71, 8'h70});

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      w = {$urandom, $urandom};
      step(($urandom_range(0, 3) == 0) ? 4'b0000 : NREQ'($urandom),
           NREQ'($urandom), w);
    end

    // mid-grant reset: lock keeps requester 0 in GRANT, then reset between edges
    step(4'b0000, 4'b0000, '0);
    step(4'b0000, 4'b0000, '0);
    step(4'b0000, 4'b0000, '0);
    step(4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h5A});
    step(4'b0001, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h77});
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    #1;
    req = '0; lock = '0;
    rst = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 0);
    chk("async_q", 32'(q), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_owner", 32'(owner), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    // arbitration after release starts from index 0
    repeat (2) step(4'b1010, 4'b0000, {8'hB3, 8'h00, 8'hB1, 8'h00});
    step(4'b0000, 4'b0000, '0);

    // drain the scoreboard within a bounded wait
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
